// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl_pkg
// Purpose  : Shared types and constants for the branch sequencing controller.
//            - state_t       : controller state encoding (2 bits)
//            - FLUSH_CYCLES_* : legal range of the flush-window length
//            - FLUSH_CNT_W    : width of the flush down-counter
// Revision : 1.0  initial release
// ============================================================================
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EX  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 7;
  localparam int FLUSH_CNT_W      = 3;

endpackage : branch_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; cleared only by reset.
// Ports    : clk   - clock (rising edge)
//            rst_n - asynchronous active-low reset
//            inc   - count enable for this cycle
//            count - current count value (WIDTH bits)
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Purpose  : Branch sequencing controller. Stalls fetch while a decoded branch
//            is unresolved, issues a one-cycle PC redirect for a taken branch
//            (ex_branch & ex_zero), then flushes IF/ID for FLUSH_CYCLES cycles.
// Params   : FLUSH_CYCLES - flush window length after a redirect (1..7)
//            CNT_W        - statistics counter width
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            id_branch    - decode holds a valid branch
//            ex_resolve   - execute presents the branch outcome this cycle
//            ex_branch    - branch control bit in execute
//            ex_zero      - ALU zero flag in execute
//            stall_if     - hold PC and IF/ID register
//            pc_src       - PC mux select (1 = branch target)
//            flush_if     - clear IF/ID to a bubble
//            busy         - controller not idle
//            branch_cnt   - resolved branch count (statistics)
//            taken_cnt    - taken branch count (statistics)
// Config   : BRANCH_CTRL_STATS_EN - when defined, builds the two saturating
//            statistics counters; otherwise both count ports read 0.
// Revision : 1.0  initial release
// ============================================================================
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_branch,
  input  logic             ex_resolve,
  input  logic             ex_branch,
  input  logic             ex_zero,
  output logic             stall_if,
  output logic             pc_src,
  output logic             flush_if,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_t                  state;
  state_t                  state_nxt;
  logic [FLUSH_CNT_W-1:0]  flush_cnt;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_nxt;
  logic                    resolve_acc;   // resolution accepted this cycle
  logic                    taken_acc;     // accepted resolution was taken

  // --------------------------------------------------------------------------
  // State and flush-counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. stall_if in IDLE is the only term that
  // depends on an input; everything else is decoded from the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    stall_if      = 1'b0;
    pc_src        = 1'b0;
    flush_if      = 1'b0;
    resolve_acc   = 1'b0;
    taken_acc     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (id_branch) begin
          stall_if  = 1'b1;
          state_nxt = ST_WAIT_EX;
        end
      end

      ST_WAIT_EX: begin
        stall_if = 1'b1;
        if (ex_resolve) begin
          resolve_acc = 1'b1;
          if (ex_branch && ex_zero) begin
            taken_acc = 1'b1;
            state_nxt = ST_REDIRECT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_REDIRECT: begin
        pc_src        = 1'b1;
        flush_cnt_nxt = FLUSH_LOAD;
        state_nxt     = ST_FLUSH;
      end

      ST_FLUSH: begin
        flush_if      = 1'b1;
        flush_cnt_nxt = flush_cnt - 1'b1;
        // <= rather than == so a zero count can never trap the FSM here
        if (flush_cnt <= FLUSH_CNT_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef BRANCH_CTRL_STATS_EN
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve_acc),
    .count (branch_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken_acc),
    .count (taken_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = resolve_acc ^ taken_acc;
  assign branch_cnt   = '0;
  assign taken_cnt    = '0;
`endif

endmodule : branch_ctrl
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl
// Purpose  : Self-checking bench for branch_ctrl. Two instances share the
//            stimulus: one with FLUSH_CYCLES=1/CNT_W=2, one with
//            FLUSH_CYCLES=3/CNT_W=16. Expected per-cycle outputs are derived
//            from the branch timing (stall/redirect/flush windows) and queued
//            as stimulus is driven; a monitor pops and compares each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic id_branch, ex_resolve, ex_branch, ex_zero;

  logic        stall1, pc1, fl1, busy1;
  logic [1:0]  bc1, tc1;
  logic        stall3, pc3, fl3, busy3;
  logic [15:0] bc3, tc3;

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .ex_resolve(ex_resolve),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .stall_if(stall1), .pc_src(pc1),
    .flush_if(fl1), .busy(busy1), .branch_cnt(bc1), .taken_cnt(tc1)
  );

  branch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .ex_resolve(ex_resolve),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .stall_if(stall3), .pc_src(pc3),
    .flush_if(fl3), .busy(busy3), .branch_cnt(bc3), .taken_cnt(tc3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected outputs for one cycle, both instances. o* = {stall,pc,flush,busy}
  typedef struct {
    int          cyc;
    logic [3:0]  o1, o3;
    logic [15:0] b1, t1, b3, t3;
  } exp_t;

  exp_t sb[$];
  int   cyc_no = 0;

  // Model statistics counters
  int mb1 = 0, mt1 = 0, mb3 = 0, mt3 = 0;

  // Output pattern of cycle k of a branch whose resolve arrives at cycle d
  // (id_branch at cycle 0). d = -1 describes an idle cycle.
  function automatic logic [3:0] exp_out(int k, int d, bit tk, int fc);
    logic s, p, f, b;
    s = (k <= d);
    p = tk && (k == d + 1);
    f = tk && (k >= d + 2) && (k < d + 2 + fc);
    b = ((k >= 1) && (k <= d)) || p || f;
    return {s, p, f, b};
  endfunction

  function automatic void push_exp(int k, int d, bit tk);
    exp_t e;
    e.cyc = cyc_no;
    e.o1  = exp_out(k, d, tk, 1);
    e.o3  = exp_out(k, d, tk, 3);
    e.b1  = 16'(mb1); e.t1 = 16'(mt1);
    e.b3  = 16'(mb3); e.t3 = 16'(mt3);
    sb.push_back(e);
    cyc_no++;
  endfunction

  function automatic void model_resolve(bit tk);
`ifdef BRANCH_CTRL_STATS_EN
    if (mb1 < 3) mb1++;
    if (tk && mt1 < 3) mt1++;
    mb3++;
    if (tk) mt3++;
`else
    if (tk) begin end
`endif
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("c%0d out1{st,pc,fl,bz}", e.cyc), {28'd0, stall1, pc1, fl1, busy1}, {28'd0, e.o1});
      check($sformatf("c%0d out3{st,pc,fl,bz}", e.cyc), {28'd0, stall3, pc3, fl3, busy3}, {28'd0, e.o3});
      check($sformatf("c%0d bcnt1", e.cyc), {30'd0, bc1}, {16'd0, e.b1});
      check($sformatf("c%0d tcnt1", e.cyc), {30'd0, tc1}, {16'd0, e.t1});
      check($sformatf("c%0d bcnt3", e.cyc), {16'd0, bc3}, {16'd0, e.b3});
      check($sformatf("c%0d tcnt3", e.cyc), {16'd0, tc3}, {16'd0, e.t3});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      id_branch = 0; ex_resolve = 0; ex_branch = 0; ex_zero = 0;
      push_exp(0, -1, 1'b0);
    end
  endtask

  // One branch: id_branch at cycle 0, resolve at cycle d. With noise set,
  // id_branch is pulsed in REDIRECT/first FLUSH and ex_resolve (taken values)
  // is held high after the resolve cycle; all of it must be ignored.
  task automatic run(input int d, input bit br, input bit z, input bit noise, input int cut);
    bit tk;
    int len;
    tk  = br & z;
    len = d + 1 + (tk ? 4 : 0);
    if (cut < len) len = cut;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      id_branch  = (k == 0) || (noise && tk && (k == d + 1 || k == d + 2));
      ex_resolve = (k == d) || (noise && k > d);
      if (k == d) begin
        ex_branch = br; ex_zero = z;
      end else if (noise && k > d) begin
        ex_branch = 1'b1; ex_zero = 1'b1;
      end else begin
        ex_branch = 1'($urandom_range(0, 1));
        ex_zero   = 1'($urandom_range(0, 1));
      end
      push_exp(k, d, tk);
      if (k == d) model_resolve(tk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out1"}, {28'd0, stall1, pc1, fl1, busy1}, 32'd0);
    check({tag, " out3"}, {28'd0, stall3, pc3, fl3, busy3}, 32'd0);
    check({tag, " cnt1"}, {28'd0, bc1, tc1}, 32'd0);
    check({tag, " cnt3"}, {bc3, tc3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; id_branch = 0; ex_resolve = 0; ex_branch = 0; ex_zero = 0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    idle(2);
    run(1, 1, 1, 0, 99);   // taken, resolve next cycle
    idle(1);
    run(1, 1, 0, 0, 99);   // not taken (zero clear)
    run(4, 1, 1, 0, 99);   // delayed resolve, taken
    run(2, 1, 1, 1, 99);   // taken with ignored id_branch/ex_resolve pulses
    run(1, 1, 1, 0, 99);   // back-to-back: accepted in first IDLE cycle
    run(3, 0, 1, 0, 99);   // ex_branch=0 resolves as not taken
    run(1, 1, 1, 1, 99);   // fifth taken branch, saturates 2-bit counters
    idle(2);

    // Asynchronous reset in the middle of the flush window
    run(1, 1, 1, 0, 4);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    check_all_zero("async reset mid-flush");
    mb1 = 0; mt1 = 0; mb3 = 0; mt3 = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("busy after release", {30'd0, busy1, busy3}, 32'd0);

    run(1, 1, 1, 0, 99);
    idle(2);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_branch_ctrl
`default_nettype wire
